rom_arbiter: RTL and testbench

- Shares one asynchronous ROM (combinational read, `DEPTH` x `WIDTH`) between `NREQ` requesters.
- Typical requesters in the VGA cube design: the sprite/palette lookup, the vertex table reader and the text overlay.
- Round-robin arbitration with a per-requester valid/ready request handshake.
- The ROM output is registered, so each granted read returns exactly one cycle later, tagged with the requester ID.

---
 rtl/rom_arbiter_pkg.sv | 23 ++
 rtl/rom_arbiter_if.sv | 39 +++
 rtl/rom_arbiter_rr_pick.sv | 56 +++++
 rtl/rom_arbiter.sv | 77 +++++++
 tb/tb_rom_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// rom_arb_pkg: constants and helpers shared by the ROM arbiter slice.
//   NREQ_DEF/WIDTH_DEF/DEPTH_DEF : default geometry shared with the ROM instances
//   MAX_NREQ/MAX_IDW             : upper bound of the requester count and its index width
//   onehot(idx, n)               : one-hot decode of idx, bits at or above n forced low
package rom_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 256;
  localparam int MAX_NREQ  = 8;
  localparam int MAX_IDW   = 3;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDW-1:0] idx,
                                                 input int unsigned n);
    logic [MAX_NREQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < n && idx == MAX_IDW'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: request/response bundle between the requesters, the ROM and the arbiter.
//   en        : arbitration enable
//   req_valid : per-requester read request
//   req_addr  : packed addresses, requester i at [i*ADDRW +: ADDRW]
//   req_ready : one-hot (or zero) grant
//   rom_addr  : address presented to the external ROM
//   rom_data  : combinational ROM read data
//   rsp_valid : one-hot registered response strobe
//   rsp_id    : index of the responding requester
//   rsp_data  : registered ROM data
// master = requester/ROM side, slave = arbiter side.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDRW = $clog2(DEPTH_DEF),
  parameter int IDW   = $clog2(NREQ)
);
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ-1:0]       req_ready;
  logic [ADDRW-1:0]      rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output en, req_valid, req_addr, rom_data,
    input  req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  en, req_valid, req_addr, rom_data,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req    : request vector (already gated by enable)
//   i_ptr    : highest-priority index
//   o_winner : winning index; equals i_ptr when nothing is requested
//   o_grant  : one-hot grant (zero when nothing is requested)
//   o_any    : at least one request present
// Rotates the request vector so i_ptr lands at bit 0, priority-encodes the
// lowest set bit, then rotates the offset back with an explicit modulo compare.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_winner,
  output logic [NREQ-1:0] o_grant,
  output logic            o_any
);
  localparam logic [IDW:0] L_N = (IDW+1)'(NREQ);

  logic [NREQ-1:0]     w_rot;
  logic [IDW-1:0]      w_off;
  logic [IDW:0]        w_sum;
  logic [MAX_NREQ-1:0] w_oh;

  always_comb begin
    w_rot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = 32'(i_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      w_rot[k] = i_req[idx];
    end
  end

  always_comb begin
    o_any = 1'b0;
    w_off = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_rot[k] && !o_any) begin
        o_any = 1'b1;
        w_off = IDW'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= L_N) w_sum = w_sum - L_N;
    o_winner = w_sum[IDW-1:0];
    w_oh     = onehot(MAX_IDW'(o_winner), NREQ);
    o_grant  = o_any ? w_oh[NREQ-1:0] : '0;
  end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one combinational ROM between NREQ requesters.
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rom_arbiter_if (requests, ROM address/data, responses)
// A grant transfers when valid & ready; the ROM word is registered and returned
// one cycle later with a one-hot rsp_valid and the requester ID.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus
);
  localparam logic [IDW-1:0] L_LAST = IDW'(NREQ - 1);

  logic [IDW-1:0]   r_ptr;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_win;
  logic             w_any;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [ADDRW-1:0] w_addr_sel;

  // Gating with rst_n keeps ready low for the whole reset interval.
  assign w_req = (bus.en && rst_n) ? bus.req_valid : '0;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  // With no request the picker returns ptr, so the idle address is req_addr[ptr].
  always_comb begin
    w_addr_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_addr_sel = bus.req_addr[i*ADDRW +: ADDRW];
    end
  end

  // Explicit wrap so a non-power-of-two NREQ never lets ptr reach NREQ.
  assign w_ptr_nxt = (w_win == L_LAST) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_any) begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= w_grant;
      r_rsp_id    <= w_win;
      r_rsp_data  <= bus.rom_data;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rom_addr  = w_addr_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: an NREQ=4 and an NREQ=3 instance run side by side,
// both against a ROM holding mem[a] = a ^ 8'hFF.
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_arbiter_if #(.NREQ(4), .WIDTH(8), .ADDRW(8), .IDW(2)) b4 ();
  rom_arbiter_if #(.NREQ(3), .WIDTH(8), .ADDRW(8), .IDW(2)) b3 ();

  rom_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(256)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  rom_arbiter #(.NREQ(3), .WIDTH(8), .DEPTH(256)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  assign b4.rom_data = b4.rom_addr ^ 8'hFF;
  assign b3.rom_data = b3.rom_addr ^ 8'hFF;

  // Stimulus per instance (index 0 = NREQ 4, index 1 = NREQ 3)
  logic       t_en    [2];
  logic [7:0] t_valid [2];
  logic [7:0] t_addr  [2][8];

  always_comb begin
    b4.en        = t_en[0];
    b4.req_valid = t_valid[0][3:0];
    b4.req_addr  = '0;
    for (int i = 0; i < 4; i++) b4.req_addr[i*8 +: 8] = t_addr[0][i];
    b3.en        = t_en[1];
    b3.req_valid = t_valid[1][2:0];
    b3.req_addr  = '0;
    for (int i = 0; i < 3; i++) b3.req_addr[i*8 +: 8] = t_addr[1][i];
  end

  // Reference model state
  int         m_ptr  [2];
  logic [7:0] m_rv   [2];
  int         m_id   [2];
  logic [7:0] m_data [2];
  logic [7:0] m_pend [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nreq_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_rv[d] = '0; m_id[d] = 0; m_data[d] = '0; m_pend[d] = '0;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_rv4"},   32'(b4.rsp_valid), 32'(m_rv[0]));
    check({tag, "_id4"},   32'(b4.rsp_id),    32'(m_id[0]));
    check({tag, "_data4"}, 32'(b4.rsp_data),  32'(m_data[0]));
    check({tag, "_ptr4"},  32'(u_dut4.r_ptr), 32'(m_ptr[0]));
    check({tag, "_rv3"},   32'(b3.rsp_valid), 32'(m_rv[1]));
    check({tag, "_id3"},   32'(b3.rsp_id),    32'(m_id[1]));
    check({tag, "_data3"}, 32'(b3.rsp_data),  32'(m_data[1]));
    check({tag, "_ptr3"},  32'(u_dut3.r_ptr), 32'(m_ptr[1]));
  endtask

  // One clock cycle: called at posedge+1 with stimulus set, returns at next posedge+1.
  task automatic tick();
    logic [7:0] rdy_e [2];
    int         w_e   [2];
    bit         g     [2];
    logic [7:0] rdy_o, addr_o;
    int         n, idx;
    #2;
    for (int d = 0; d < 2; d++) begin
      n = nreq_of(d);
      g[d] = 0; w_e[d] = 0; rdy_e[d] = '0;
      if (t_en[d] && rst_n) begin
        for (int k = 0; k < n; k++) begin
          idx = (m_ptr[d] + k) % n;
          if (!g[d] && t_valid[d][idx]) begin g[d] = 1; w_e[d] = idx; end
        end
      end
      if (g[d]) rdy_e[d][w_e[d]] = 1'b1;
      rdy_o  = (d == 0) ? 8'(b4.req_ready) : 8'(b3.req_ready);
      addr_o = (d == 0) ? b4.rom_addr : b3.rom_addr;
      check($sformatf("ready%0d", d), 32'(rdy_o), 32'(rdy_e[d]));
      if (g[d]) check($sformatf("rom_addr%0d", d), 32'(addr_o), 32'(t_addr[d][w_e[d]]));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n = nreq_of(d);
      if (g[d]) begin
        m_rv[d]   = 8'(1 << w_e[d]);
        m_id[d]   = w_e[d];
        m_data[d] = t_addr[d][w_e[d]] ^ 8'hFF;
        m_ptr[d]  = (w_e[d] + 1) % n;
      end else begin
        m_rv[d] = '0;
      end
      m_pend[d] = t_valid[d] & ~rdy_e[d] & 8'((1 << n) - 1);
    end
    check_regs("rsp");
  endtask

  // Mid-cycle asynchronous reset, released at posedge+1.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rv4",  32'(b4.rsp_valid), 32'h0);
    check("rst_rdy4", 32'(b4.req_ready), 32'h0);
    check("rst_rv3",  32'(b3.rsp_valid), 32'h0);
    check("rst_rdy3", 32'(b3.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_regs("rst");
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      t_en[d] = 1'b1; t_valid[d] = '0;
      for (int i = 0; i < 8; i++) t_addr[d][i] = '0;
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_regs("init");

    // Single requester 2, consecutive addresses
    t_valid[0] = 8'b0100;
    for (int i = 0; i < 4; i++) begin
      t_addr[0][2] = 8'(8'h10 + i);
      tick();
      check("single_data", 32'(b4.rsp_data), 32'(8'hEF - i));
      check("single_id",   32'(b4.rsp_id),   32'd2);
    end

    // Reset with a response in the register; first grant then goes to lowest valid
    t_valid[0] = 8'b0110;
    do_reset();
    tick();
    check("post_rst_id", 32'(b4.rsp_id), 32'd1);

    // Full contention from ptr=0
    do_reset();
    t_valid[0] = 8'b1111;
    for (int i = 0; i < 4; i++) t_addr[0][i] = 8'(i);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fc_order", 32'(b4.rsp_id), 32'(i % 4));
      check("fc_data",  32'(b4.rsp_data), 32'((i % 4) ^ 8'hFF));
    end
    check("fc_ptr_end", 32'(u_dut4.r_ptr), 32'd0);

    // Skip idle requesters from ptr=1
    do_reset();
    t_valid[0] = 8'b0001;
    tick();
    t_valid[0] = 8'b1001;
    tick(); check("skip_a", 32'(b4.rsp_id), 32'd3);
    tick(); check("skip_b", 32'(b4.rsp_id), 32'd0);
    tick(); check("skip_c", 32'(b4.rsp_id), 32'd3);

    // Enable gating after a grant to 1
    do_reset();
    t_valid[0] = 8'b0010;
    tick();
    check("en_grant1", 32'(b4.rsp_valid), 32'b0010);
    t_en[0] = 1'b0;
    t_valid[0] = 8'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_off_rv", 32'(b4.rsp_valid), 32'h0);
    end
    t_en[0] = 1'b1;
    tick();
    check("en_on_id", 32'(b4.rsp_id), 32'd2);

    // NREQ=3 wrap
    do_reset();
    t_valid[0] = '0;
    t_valid[1] = 8'b111;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("wrap3_id", 32'(b3.rsp_id), 32'(i % 3));
    end

    // Randomized traffic on both instances, requesters hold pending requests
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        t_en[d] = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < nreq_of(d); i++) begin
          if (!m_pend[d][i]) begin
            t_valid[d][i] = ($urandom_range(0, 99) < 55);
            t_addr[d][i]  = 8'($urandom);
          end
        end
      end
      if (c == 150 || c == 300) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
